mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_pkg.sv | 13 +
 rtl/mul_step_add.sv | 31 +++
 rtl/mul_seq_ctrl.sv | 102 ++++++++++
 tb/tb_mul_seq_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the sequential 32x32 multiplier.
// Width is fixed; CNT_LAST marks the final RUN cycle of the full-length sequence.
package mul_pkg;
  localparam int MUL_W = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mul_step_add.sv
// One shift-and-add step: conditional 33-bit accumulate, operand shifts, overflow term.
// Purely combinational; the caller owns all state.
module mul_step_add
  import mul_pkg::*;
(
  input  logic [MUL_W-1:0] acc,
  input  logic [MUL_W-1:0] a_sh,
  input  logic [MUL_W-1:0] b_sh,
  input  logic             lost,
  output logic [MUL_W-1:0] acc_nxt,
  output logic [MUL_W-1:0] a_nxt,
  output logic [MUL_W-1:0] b_nxt,
  output logic             lost_nxt,
  output logic             over_term
);
  logic [MUL_W:0] sum;

  always_comb begin
    sum       = {1'b0, acc} + {1'b0, a_sh};
    acc_nxt   = acc;
    over_term = 1'b0;
    // A multiplicand bit already shifted out only matters once it would be added.
    if (b_sh[0]) begin
      acc_nxt   = sum[MUL_W-1:0];
      over_term = sum[MUL_W] | lost;
    end
    a_nxt    = a_sh << 1;
    b_nxt    = b_sh >> 1;
    lost_nxt = lost | a_sh[MUL_W-1];
  end
endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned 32x32 multiplier (low 32 bits + overflow flag), IDLE/RUN/DONE FSM.
// Define MUL_SEQ_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier is zero.
module mul_seq_ctrl
  import mul_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MUL_W-1:0] product,
  output logic             over,
  output logic             busy
);
  state_t           state;
  state_t           state_nxt;
  logic [MUL_W-1:0] a_sh;
  logic [MUL_W-1:0] b_sh;
  logic [MUL_W-1:0] acc;
  logic             over_acc;
  logic             lost;
  logic [CNT_W-1:0] cnt;

  logic [MUL_W-1:0] acc_nxt;
  logic [MUL_W-1:0] a_nxt;
  logic [MUL_W-1:0] b_nxt;
  logic             lost_nxt;
  logic             over_term;
  logic             run_last;

  mul_step_add u_step (
    .acc       (acc),
    .a_sh      (a_sh),
    .b_sh      (b_sh),
    .lost      (lost),
    .acc_nxt   (acc_nxt),
    .a_nxt     (a_nxt),
    .b_nxt     (b_nxt),
    .lost_nxt  (lost_nxt),
    .over_term (over_term)
  );

`ifdef MUL_SEQ_EARLY_TERM_EN
  assign run_last = (b_nxt == '0);
`else
  assign run_last = (cnt == CNT_LAST);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_RUN;
      S_RUN:   if (run_last) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      over_acc <= 1'b0;
      lost     <= 1'b0;
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            acc      <= '0;
            over_acc <= 1'b0;
            lost     <= 1'b0;
            cnt      <= '0;
          end
        end
        S_RUN: begin
          acc      <= acc_nxt;
          over_acc <= over_acc | over_term;
          lost     <= lost_nxt;
          a_sh     <= a_nxt;
          b_sh     <= b_nxt;
          cnt      <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign product   = acc;
  assign over      = over_acc;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: hand-computed products, latency, hold/backpressure, reset abort.
module tb_mul_seq_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        over;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mul_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .over      (over),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  // Cycles from the accept cycle to the first cycle with out_valid high.
  function automatic int exp_lat(input logic [31:0] bv);
`ifdef MUL_SEQ_EARLY_TERM_EN
    int r;
    r = 1;
    for (int i = 0; i < 32; i++) if (bv[i]) r = i + 1;
    return r + 1;
`else
    return 33;
`endif
  endfunction

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] ep, input logic eo,
                        input int hold, input string tag);
    int  n;
    bit  seen;
    @(negedge clk);
    chk(tag, "in_ready_idle", {31'b0, in_ready}, 32'd1);
    a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); @(negedge clk);
      n++;
      // Requests with different operands while busy must be ignored.
      in_valid = n[0];
      a = ~ta; b = ~tb_v;
      if (out_valid) seen = 1;
    end
    in_valid = 1'b0;
    chk(tag, "latency", 32'(n), 32'(exp_lat(tb_v)));
    chk(tag, "product", product, ep);
    chk(tag, "over", {31'b0, over}, {31'b0, eo});
    chk(tag, "busy_done", {31'b0, busy}, 32'd1);
    chk(tag, "in_ready_done", {31'b0, in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a = 32'h1; b = 32'h1;
      @(posedge clk); @(negedge clk);
      chk(tag, "hold_valid", {31'b0, out_valid}, 32'd1);
      chk(tag, "hold_product", product, ep);
      chk(tag, "hold_over", {31'b0, over}, {31'b0, eo});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk(tag, "post_valid", {31'b0, out_valid}, 32'd0);
    chk(tag, "post_ready", {31'b0, in_ready}, 32'd1);
    chk(tag, "post_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    @(negedge clk);
    chk("reset", "in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset", "out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset", "busy", {31'b0, busy}, 32'd0);
    chk("reset", "product", product, 32'd0);
    chk("reset", "over", {31'b0, over}, 32'd0);
    reset = 1'b0;

    run_op(32'd3,          32'd5,          32'd15,         1'b0, 0, "3x5");
    run_op(32'h8000_0000,  32'd2,          32'h0,          1'b1, 0, "msb_x2");
    run_op(32'h0001_0000,  32'h0001_0000,  32'h0,          1'b1, 0, "2p16_sq");
    run_op(32'h0000_FFFF,  32'h0001_0001,  32'hFFFF_FFFF,  1'b0, 0, "ffff_x10001");
    run_op(32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 0, "max_x1");
    run_op(32'd1,          32'h8000_0000,  32'h8000_0000,  1'b0, 0, "1_xmsb");
    run_op(32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, 0, "msb_x1");
    run_op(32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1'b1, 0, "max_sq");
    run_op(32'h1234_5678,  32'h10,         32'h2345_6780,  1'b1, 0, "shift4");
    run_op(32'h0001_0000,  32'h0000_FFFF,  32'hFFFF_0000,  1'b0, 0, "edge_fit");
    run_op(32'd0,          32'hFFFF_FFFF,  32'd0,          1'b0, 0, "zero_a");
    run_op(32'd9,          32'd0,          32'd0,          1'b0, 0, "zero_b");
    run_op(32'd1000,       32'd1000,       32'd1000000,    1'b0, 5, "hold5");

    // Abort an operation ten RUN cycles in.
    @(negedge clk);
    a = 32'd5; b = 32'd9; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    chk("abort", "busy_run", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort", "out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort", "in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort", "product", product, 32'd0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      chk("abort", "no_result", {31'b0, out_valid}, 32'd0);
    end
    run_op(32'd7, 32'd6, 32'd42, 1'b0, 0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
